// File: rtl/qpsk_pkg.sv
// qpsk_pkg
// Shared definitions for the QPSK modulator/demodulator pair:
//   - serialiser and PRBS checker state enums
//   - PRBS7 geometry (x^7 + x^6 + 1, taps at state bits 6 and 5)
//   - dibit ordering: the I decision lives in dibit[1] and goes out first
package qpsk_pkg;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_BIT1 = 2'd1,
    SER_BIT0 = 2'd2
  } ser_state_t;

  typedef enum logic {
    CHK_SEED  = 1'b0,
    CHK_TRACK = 1'b1
  } chk_state_t;

  localparam int PRBS_W     = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  // Dibit bit positions; the mapper uses the same indices so I is always first.
  localparam int DIBIT_FIRST  = 1;
  localparam int DIBIT_SECOND = 0;

  // Next PRBS7 bit predicted from the current shift-register contents.
  function automatic logic prbs7_next(input logic [PRBS_W-1:0] s);
    return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/dibit_fifo.sv
// dibit_fifo
// Synchronous first-word-fall-through FIFO with full/empty flags. A write
// while full (judged on pre-edge occupancy) is dropped and sets a sticky
// overflow flag that only reset clears.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_wr_en/i_wr_data  write strobe and data
//   i_rd_en         pop the head entry (ignored when empty)
//   o_rd_data       head entry, valid while !o_empty
//   o_full/o_empty  occupancy flags
//   o_overflow      sticky drop flag
module dibit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr    = i_wr_en && !w_full;
  assign w_rd    = i_rd_en && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (i_wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/qpsk_demod_prbs_check.sv
// qpsk_demod_prbs_check
// Hard-decision QPSK demodulator with dibit buffer, ready/valid bit
// serialiser and self-synchronising PRBS7 checker for loopback BER tests.
//
//   serialiser state | meaning
//   SER_IDLE         | nothing to send, bit_valid low
//   SER_BIT1         | presenting the first (I) bit of the held dibit
//   SER_BIT0         | presenting the second (Q) bit of the held dibit
//
//   checker state    | meaning
//   CHK_SEED         | loading 7 received bits into the PRBS register
//   CHK_TRACK        | free-running prediction, counting bits and errors
//
// Ports:
//   clk, reset             clock, async active-low reset
//   I_in, Q_in, valid_in   signed symbol and strobe
//   bit_out, bit_valid     serialised bit stream (registered)
//   bit_ready              downstream accept
//   locked                 checker in TRACK
//   bit_count, err_count   saturating compared-bit / mismatch counters
//   overflow               sticky symbol-drop flag
module qpsk_demod_prbs_check
  import qpsk_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_LEN     = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       I_in,
  input  logic [7:0]       Q_in,
  input  logic             valid_in,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow
);

  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WE_W-1:0] LOSS_LIM = WE_W'(LOSS_THRESH);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [2:0]      SEED_LAST = 3'(PRBS_W - 1);

  // Decision and FIFO
  logic [1:0] w_wr_dibit;
  logic [1:0] w_fifo_data;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_fifo_ovf;
  logic       w_pop;
  logic       w_unused_mag;

  // Sign bit is the decision; zero is non-negative and decodes as 0.
  always_comb begin
    w_wr_dibit               = '0;
    w_wr_dibit[DIBIT_FIRST]  = I_in[7];
    w_wr_dibit[DIBIT_SECOND] = Q_in[7];
  end

  assign w_unused_mag = ^{I_in[6:0], Q_in[6:0], w_fifo_full};

  dibit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_wr_en    (valid_in),
    .i_wr_data  (w_wr_dibit),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_overflow (w_fifo_ovf)
  );

  // Serialiser
  ser_state_t r_ser_state;
  ser_state_t w_ser_next;
  logic [1:0] r_dibit;
  logic [1:0] w_dibit_nxt;
  logic       r_bit_out;
  logic       r_bit_valid;
  logic       w_bit_out_nxt;
  logic       w_bit_valid_nxt;
  logic       w_xfer;

  assign w_xfer = r_bit_valid && bit_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ser_state <= SER_IDLE;
      r_dibit     <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_ser_state <= w_ser_next;
      r_dibit     <= w_dibit_nxt;
      r_bit_out   <= w_bit_out_nxt;
      r_bit_valid <= w_bit_valid_nxt;
    end
  end

  // Popping from BIT0 on the same edge as the last transfer avoids a bubble.
  always_comb begin
    w_ser_next = r_ser_state;
    w_pop      = 1'b0;
    case (r_ser_state)
      SER_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop      = 1'b1;
          w_ser_next = SER_BIT1;
        end
      end
      SER_BIT1: begin
        if (w_xfer) w_ser_next = SER_BIT0;
      end
      SER_BIT0: begin
        if (w_xfer) begin
          if (!w_fifo_empty) begin
            w_pop      = 1'b1;
            w_ser_next = SER_BIT1;
          end else begin
            w_ser_next = SER_IDLE;
          end
        end
      end
      default: w_ser_next = SER_IDLE;
    endcase
  end

  always_comb begin
    w_dibit_nxt     = w_pop ? w_fifo_data : r_dibit;
    w_bit_valid_nxt = (w_ser_next != SER_IDLE);
    w_bit_out_nxt   = 1'b0;
    case (w_ser_next)
      SER_BIT1: w_bit_out_nxt = w_dibit_nxt[DIBIT_FIRST];
      SER_BIT0: w_bit_out_nxt = w_dibit_nxt[DIBIT_SECOND];
      default:  w_bit_out_nxt = 1'b0;
    endcase
  end

  // PRBS7 checker
  chk_state_t        r_chk_state;
  chk_state_t        w_chk_next;
  logic              r_locked;
  logic              w_locked_nxt;
  logic [PRBS_W-1:0] r_prbs;
  logic [2:0]        r_seed_cnt;
  logic [WC_W-1:0]   r_win_cnt;
  logic [WE_W-1:0]   r_win_err;
  logic [CNT_W-1:0]  r_bit_count;
  logic [CNT_W-1:0]  r_err_count;
  logic              w_rx;
  logic              w_exp;
  logic              w_mism;
  logic [WE_W-1:0]   w_win_err_inc;
  logic              w_seed_done;
  logic              w_loss;
  logic              w_win_end;

  assign w_rx          = r_bit_out;
  assign w_exp         = prbs7_next(r_prbs);
  assign w_mism        = w_rx ^ w_exp;
  assign w_win_err_inc = r_win_err + WE_W'(w_mism);
  assign w_seed_done   = (r_seed_cnt == SEED_LAST);
  assign w_loss        = (w_win_err_inc >= LOSS_LIM);
  assign w_win_end     = (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_state <= CHK_SEED;
      r_locked    <= 1'b0;
    end else begin
      r_chk_state <= w_chk_next;
      r_locked    <= w_locked_nxt;
    end
  end

  always_comb begin
    w_chk_next = r_chk_state;
    if (w_xfer) begin
      case (r_chk_state)
        CHK_SEED:  if (w_seed_done) w_chk_next = CHK_TRACK;
        CHK_TRACK: if (w_loss)      w_chk_next = CHK_SEED;
        default:   w_chk_next = CHK_SEED;
      endcase
    end
  end

  always_comb begin
    w_locked_nxt = (w_chk_next == CHK_TRACK);
  end

  // In TRACK the register is fed with its own prediction, so a corrupted
  // received bit costs exactly one error instead of spreading through the taps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prbs      <= '0;
      r_seed_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_bit_count <= '0;
      r_err_count <= '0;
    end else if (w_xfer) begin
      if (r_chk_state == CHK_SEED) begin
        r_prbs     <= {r_prbs[PRBS_W-2:0], w_rx};
        r_seed_cnt <= w_seed_done ? 3'd0 : r_seed_cnt + 3'd1;
        if (w_seed_done) begin
          r_win_cnt <= '0;
          r_win_err <= '0;
        end
      end else begin
        r_prbs <= {r_prbs[PRBS_W-2:0], w_exp};
        if (r_bit_count != '1) r_bit_count <= r_bit_count + CNT_W'(1);
        if (w_mism && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
        if (w_loss) begin
          r_seed_cnt <= '0;
          r_win_cnt  <= '0;
          r_win_err  <= '0;
        end else if (w_win_end) begin
          r_win_cnt <= '0;
          r_win_err <= '0;
        end else begin
          r_win_cnt <= r_win_cnt + WC_W'(1);
          r_win_err <= w_win_err_inc;
        end
      end
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign locked    = r_locked;
  assign bit_count = r_bit_count;
  assign err_count = r_err_count;
  assign overflow  = w_fifo_ovf;

endmodule

// File: tb/tb_qpsk_demod_prbs_check.sv
// Bench for qpsk_demod_prbs_check: directed scenarios plus a transaction-level
// reference (symbol queue, held-bit queue, last-seven-bits PRBS predictor)
// compared against the DUT on every falling edge.
module tb_qpsk_demod_prbs_check;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int WIN_LEN = 16;
  localparam int LOSS    = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       I_in = '0;
  logic [7:0]       Q_in = '0;
  logic             valid_in = 1'b0;
  logic             bit_ready = 1'b0;
  logic             bit_out;
  logic             bit_valid;
  logic             locked;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;
  logic             overflow;

  qpsk_demod_prbs_check #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W),
    .WIN_LEN    (WIN_LEN),
    .LOSS_THRESH(LOSS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .I_in      (I_in),
    .Q_in      (Q_in),
    .valid_in  (valid_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .locked    (locked),
    .bit_count (bit_count),
    .err_count (err_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [1:0] m_fifo[$];
  bit         m_hold[$];
  bit         m_ref[$];
  bit         m_ovf;
  bit         m_locked;
  int         m_bits;
  int         m_errs;
  int         m_win_n;
  int         m_win_e;
  int         lock_drops;
  bit         prev_locked;
  int         mon_pre_size;
  logic [1:0] mon_d;
  bit         mon_rx;
  bit         mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      m_fifo.delete(); m_hold.delete(); m_ref.delete();
      m_ovf = 0; m_locked = 0; m_bits = 0; m_errs = 0;
      m_win_n = 0; m_win_e = 0; prev_locked = 0;
    end else begin
      checks++;
      if (bit_valid !== (m_hold.size() != 0)) begin
        failures++; $display("FAIL mon_bit_valid: got %0b expected %0b", bit_valid, m_hold.size() != 0);
      end
      if (m_hold.size() != 0) begin
        checks++;
        if (bit_out !== m_hold[0]) begin
          failures++; $display("FAIL mon_bit_out: got %0b expected %0b", bit_out, m_hold[0]);
        end
      end
      checks++;
      if (locked !== m_locked) begin
        failures++; $display("FAIL mon_locked: got %0b expected %0b", locked, m_locked);
      end
      checks++;
      if (bit_count !== CNT_W'(m_bits)) begin
        failures++; $display("FAIL mon_bit_count: got %0d expected %0d", bit_count, m_bits);
      end
      checks++;
      if (err_count !== CNT_W'(m_errs)) begin
        failures++; $display("FAIL mon_err_count: got %0d expected %0d", err_count, m_errs);
      end
      checks++;
      if (overflow !== m_ovf) begin
        failures++; $display("FAIL mon_overflow: got %0b expected %0b", overflow, m_ovf);
      end
      if (prev_locked && !locked) lock_drops++;
      prev_locked = locked;

      // Advance the model through the coming rising edge.
      mon_pre_size = m_fifo.size();
      if (m_hold.size() != 0 && bit_ready) begin
        mon_rx = m_hold.pop_front();
        if (!m_locked) begin
          m_ref.push_back(mon_rx);
          if (m_ref.size() == 7) begin
            m_locked = 1; m_win_n = 0; m_win_e = 0;
          end
        end else begin
          mon_e = m_ref[0] ^ m_ref[1];
          void'(m_ref.pop_front());
          m_ref.push_back(mon_e);
          if (m_bits < MAXC) m_bits++;
          if (mon_rx != mon_e) begin
            if (m_errs < MAXC) m_errs++;
            m_win_e++;
          end
          if (m_win_e >= LOSS) begin
            m_locked = 0; m_ref.delete();
          end else begin
            m_win_n++;
            if (m_win_n == WIN_LEN) begin m_win_n = 0; m_win_e = 0; end
          end
        end
      end
      if (m_hold.size() == 0 && mon_pre_size != 0) begin
        mon_d = m_fifo.pop_front();
        m_hold.push_back(mon_d[1]);
        m_hold.push_back(mon_d[0]);
      end
      if (valid_in) begin
        if (mon_pre_size == DEPTH) m_ovf = 1;
        else m_fifo.push_back({I_in[7], Q_in[7]});
      end
    end
  end

  // Modulator stand-in: PRBS7 LFSR, x^7+x^6+1
  logic [6:0] gen_s;

  function automatic bit gen_bit();
    bit b;
    b = gen_s[6] ^ gen_s[5];
    gen_s = {gen_s[5:0], b};
    return b;
  endfunction

  function automatic logic [7:0] map_amp(input bit b);
    return b ? 8'hC0 : 8'h40;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] i, input logic [7:0] q);
    I_in = i; Q_in = q; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Sends n PRBS symbols at one per two cycles; symbols in flip_idx have both
  // decisions inverted when flip_both is set, otherwise only I.
  task automatic send_prbs(input int n, input int flip_a, input int flip_b, input bit flip_both);
    bit b1, b0;
    for (int k = 0; k < n; k++) begin
      b1 = gen_bit(); b0 = gen_bit();
      if (k == flip_a || k == flip_b) begin
        b1 = !b1;
        if (flip_both) b0 = !b0;
      end
      put(map_amp(b1), map_amp(b0));
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    bit_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({bit_out, bit_valid, locked, overflow} !== 4'b0 || bit_count !== '0 || err_count !== '0) begin
      failures++; $display("FAIL reset_outputs: got %0b%0b%0b%0b bc=%0d ec=%0d expected all 0",
                           bit_out, bit_valid, locked, overflow, bit_count, err_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_decision();
    logic [7:0] vi[3] = '{8'd100, 8'h00, 8'h80};
    logic [7:0] vq[3] = '{8'h9C, 8'hFF, 8'h7F};
    bit         e1[3] = '{1'b0, 1'b0, 1'b1};
    bit         e0[3] = '{1'b1, 1'b1, 1'b0};
    bit_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      put(vi[k], vq[k]);
      checks++;
      if (bit_valid !== 1'b0) begin
        failures++; $display("FAIL dec_latency_early[%0d]: got %0b expected 0", k, bit_valid);
      end
      tick();
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== e1[k]) begin
        failures++; $display("FAIL dec_first_bit[%0d]: got v=%0b b=%0b expected v=1 b=%0b", k, bit_valid, bit_out, e1[k]);
      end
      tick();
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== e0[k]) begin
        failures++; $display("FAIL dec_second_bit[%0d]: got v=%0b b=%0b expected v=1 b=%0b", k, bit_valid, bit_out, e0[k]);
      end
      tick();
      checks++;
      if (bit_valid !== 1'b0) begin
        failures++; $display("FAIL dec_idle[%0d]: got %0b expected 0", k, bit_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      I_in      = 8'($urandom);
      Q_in      = 8'($urandom);
      valid_in  = ($urandom_range(0, 2) == 0);
      bit_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    valid_in = 1'b0; bit_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_loopback();
    do_reset();
    bit_ready = 1'b1;
    gen_s = 7'b1010101;
    send_prbs(127, -1, -1, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd247 || err_count !== 16'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL loopback: got lk=%0b bc=%0d ec=%0d ov=%0b expected lk=1 bc=247 ec=0 ov=0",
                           locked, bit_count, err_count, overflow);
    end
  endtask

  task automatic test_single_error();
    send_prbs(40, 10, -1, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd327 || err_count !== 16'd1) begin
      failures++; $display("FAIL single_error: got lk=%0b bc=%0d ec=%0d expected lk=1 bc=327 ec=1",
                           locked, bit_count, err_count);
    end
  endtask

  task automatic test_burst();
    int drops0;
    drops0 = lock_drops;
    send_prbs(40, 0, 1, 1'b1);
    checks++;
    if (lock_drops !== drops0 + 1) begin
      failures++; $display("FAIL burst_unlock: got %0d lock drops expected %0d", lock_drops - drops0, 1);
    end
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd400 || err_count !== 16'd5) begin
      failures++; $display("FAIL burst_relock: got lk=%0b bc=%0d ec=%0d expected lk=1 bc=400 ec=5",
                           locked, bit_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    bit eb[10];
    bit b1, b0;
    do_reset();
    bit_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b1 = 1'($urandom); b0 = 1'($urandom);
      if (k < 5) begin eb[2*k] = b1; eb[2*k+1] = b0; end
      put(map_amp(b1), map_amp(b0));
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL bp_overflow: got %0b expected 1", overflow);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== eb[0]) begin
        failures++; $display("FAIL bp_stall[%0d]: got v=%0b b=%0b expected v=1 b=%0b", k, bit_valid, bit_out, eb[0]);
      end
      tick();
    end
    bit_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== eb[k]) begin
        failures++; $display("FAIL bp_drain[%0d]: got v=%0b b=%0b expected v=1 b=%0b", k, bit_valid, bit_out, eb[k]);
      end
      tick();
    end
    checks++;
    if (bit_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL bp_done: got v=%0b ov=%0b expected v=0 ov=1", bit_valid, overflow);
    end
  endtask

  task automatic test_mid_reset();
    bit b1, b0;
    // Rebuild lock on a fresh stream, then stall in BIT0 with symbols queued.
    do_reset();
    bit_ready = 1'b1;
    gen_s = 7'b0110011;
    send_prbs(8, -1, -1, 1'b0);
    bit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b1 = gen_bit(); b0 = gen_bit();
      put(map_amp(b1), map_amp(b0));
    end
    bit_ready = 1'b1;
    tick();
    bit_ready = 1'b0;
    checks++;
    if (bit_valid !== 1'b1 || locked !== 1'b1 || bit_count !== 16'd10) begin
      failures++; $display("FAIL mr_pre: got v=%0b lk=%0b bc=%0d expected v=1 lk=1 bc=10", bit_valid, locked, bit_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bit_out, bit_valid, locked, overflow} !== 4'b0 || bit_count !== '0 || err_count !== '0) begin
      failures++; $display("FAIL mr_async_clear: got %0b%0b%0b%0b bc=%0d ec=%0d expected all 0",
                           bit_out, bit_valid, locked, overflow, bit_count, err_count);
    end
    tick(); tick();
    reset = 1'b1;
    bit_ready = 1'b1;
    tick();
    checks++;
    if (bit_valid !== 1'b0) begin
      failures++; $display("FAIL mr_fifo_flushed: got %0b expected 0", bit_valid);
    end
    gen_s = 7'b1010101;
    send_prbs(8, -1, -1, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_count !== 16'd9 || err_count !== 16'd0) begin
      failures++; $display("FAIL mr_reseed: got lk=%0b bc=%0d ec=%0d expected lk=1 bc=9 ec=0",
                           locked, bit_count, err_count);
    end
  endtask

  initial begin
    lock_drops = 0;
    test_reset();
    test_decision();
    test_random();
    test_loopback();
    test_single_error();
    test_burst();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
